// File: rtl/program_loader.sv
// Boot-time program loader: receives a byte-stream program image, assembles
// little-endian 32-bit words, writes them to instruction memory and releases
// the core from reset only after the XOR checksum matches.
module program_loader #(
   parameter int MEMORY_DEPTH = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_reset,
   output logic        done,
   output logic        error
);

   localparam logic [7:0] DEPTH8 = 8'(MEMORY_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_HEADER, S_DATA, S_CHECK, S_DONE, S_ERROR
   } state_t;

   state_t      state_q;
   logic [7:0]  n_q, word_idx_q, acc_q;
   logic [1:0]  byte_idx_q;
   logic [23:0] asm_q;        // lower three bytes of the word being assembled
   logic        rx_ready_q, mem_we_q, cpu_reset_q, done_q, error_q;
   logic [31:0] mem_addr_q, mem_wdata_q;

   logic        accept_d, hdr_ok_d, last_word_d;
   logic [7:0]  acc_d;
   logic [31:0] word_d;

   // Handshake, next accumulator value and completed word for the current byte
   always_comb begin
      accept_d    = rx_valid & rx_ready_q;
      acc_d       = acc_q ^ rx_data;
      word_d      = {rx_data, asm_q};
      hdr_ok_d    = (rx_data != 8'd0) && (rx_data <= DEPTH8);
      last_word_d = (word_idx_q == (n_q - 8'd1));
   end

   // Loader FSM; every output is registered and updated on the transition edge
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         n_q         <= '0;
         word_idx_q  <= '0;
         byte_idx_q  <= '0;
         acc_q       <= '0;
         asm_q       <= '0;
         rx_ready_q  <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_reset_q <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         mem_we_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q    <= S_HEADER;
                  rx_ready_q <= 1'b1;
               end
            end
            S_HEADER: begin
               if (accept_d) begin
                  if (hdr_ok_d) begin
                     n_q        <= rx_data;
                     word_idx_q <= '0;
                     byte_idx_q <= '0;
                     acc_q      <= '0;
                     state_q    <= S_DATA;
                  end else begin
                     rx_ready_q <= 1'b0;
                     error_q    <= 1'b1;
                     state_q    <= S_ERROR;
                  end
               end
            end
            S_DATA: begin
               if (accept_d) begin
                  acc_q      <= acc_d;
                  byte_idx_q <= byte_idx_q + 2'd1;
                  if (byte_idx_q == 2'd3) begin
                     // Write register is separate, so the next word can start
                     // assembling on the very next cycle.
                     mem_we_q    <= 1'b1;
                     mem_wdata_q <= word_d;
                     mem_addr_q  <= {22'd0, word_idx_q, 2'b00};
                     word_idx_q  <= word_idx_q + 8'd1;
                     if (last_word_d) state_q <= S_CHECK;
                  end else begin
                     asm_q[{byte_idx_q, 3'b000} +: 8] <= rx_data;
                  end
               end
            end
            S_CHECK: begin
               if (accept_d) begin
                  rx_ready_q <= 1'b0;
                  if (rx_data == acc_q) begin
                     done_q      <= 1'b1;
                     cpu_reset_q <= 1'b0;
                     state_q     <= S_DONE;
                  end else begin
                     error_q <= 1'b1;
                     state_q <= S_ERROR;
                  end
               end
            end
            S_DONE: begin
               if (start) begin
                  rx_ready_q  <= 1'b1;
                  cpu_reset_q <= 1'b1;
                  done_q      <= 1'b0;
                  state_q     <= S_HEADER;
               end
            end
            S_ERROR: begin
               if (start) begin
                  rx_ready_q <= 1'b1;
                  error_q    <= 1'b0;
                  state_q    <= S_HEADER;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign rx_ready  = rx_ready_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_reset = cpu_reset_q;
   assign done      = done_q;
   assign error     = error_q;

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader directly upstream of the single-cycle MIPS core's program memory. It receives a program image as a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes those words into the instruction ROM's write port and holds the core in reset until the image loads with a correct checksum. Once released, the core fetches from PC 0 exactly as after a normal reset.

## Interface
Parameters:
- MEMORY_DEPTH, 32, program memory size in words; legal range 1..255.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle pulse; begins a load; sampled only in IDLE, DONE, ERROR.
- rx_data  in  8  incoming image byte.
- rx_valid  in  1  rx_data holds a byte.
- rx_ready  out  1  loader accepts a byte; transfer occurs on an edge where rx_valid and rx_ready are both 1.
- mem_we  out  1  one-cycle write strobe to program memory.
- mem_addr  out  32  byte address of the write; always a multiple of 4.
- mem_wdata  out  32  instruction word to write.
- cpu_reset  out  1  drives the core's reset; 1 = core held.
- done  out  1  image loaded and verified; core running.
- error  out  1  last load failed.

## Operation
- Image format: header byte N (word count), then 4N data bytes, least-significant byte of each word first, then one checksum byte.
- The checksum is the XOR of all 4N data bytes; the header is excluded.
- States: IDLE, HEADER, DATA, CHECK, DONE, ERROR.
- IDLE: rx_ready=0, cpu_reset=1. A start pulse moves to HEADER.
- HEADER: rx_ready=1. On accept:
  - N==0 or N>MEMORY_DEPTH: go to ERROR.
  - Otherwise: latch N, clear word_idx, byte_idx and the XOR accumulator, go to DATA.
- DATA: rx_ready=1. Each accepted byte goes into lane byte_idx of the assembly register and is XORed into the accumulator.
  - On the 4th byte (byte_idx==3), load mem_wdata with the completed word and mem_addr with word_idx*4.
  - On that same edge, increment word_idx and wrap byte_idx to 0.
  - After the 4th byte of word N-1, go to CHECK.
- CHECK: rx_ready=1. On accept, compare the byte with the accumulator: equal goes to DONE, unequal goes to ERROR.
- DONE: rx_ready=0, cpu_reset=0, done=1. A start pulse goes to HEADER, with cpu_reset=1 and done=0 on that same edge.
- ERROR: rx_ready=0, cpu_reset=1, error=1. A start pulse goes to HEADER and clears error.
- start is ignored in HEADER, DATA and CHECK.
- Partial images are not rolled back. Words already written remain in memory; the core stays held.

## Timing
- Reset values:
  - state IDLE
  - cpu_reset=1
  - rx_ready=0, mem_we=0
  - mem_addr=0, mem_wdata=0
  - done=0, error=0
  - all counters and the accumulator 0
- Reset takes priority over every other input, including mid-load. The loader returns to IDLE with no further mem_we.
- rx_ready is a registered output. It rises the cycle after entering HEADER and falls the cycle after entering DONE or ERROR.
- mem_we is high for exactly one cycle: the cycle after the edge that accepted the 4th byte of a word.
  - mem_addr and mem_wdata are valid during that cycle and hold until the next write.
- Back-to-back bytes are accepted one per cycle, with no stall; the write register is separate from the assembly register. The maximum write rate is one per 4 cycles.
- Gaps in rx_valid stall progress without any other side effect.
- done/error and the cpu_reset change become visible on the edge after checksum (or bad header) acceptance.
- The core's first fetch is the cycle after cpu_reset falls.

## Test plan
- Reset held for 2 cycles -> all outputs at reset values. rx_valid=1 with no start -> no accept, no mem_we.
- Load N=2: stream 02, 05,00,08,20, 20,50,09,01, checksum 55 ->
  - mem_we at addr 0x0 with data 0x20080005.
  - mem_we at addr 0x4 with data 0x01095020.
  - done=1, cpu_reset=0, rx_ready=0.
- Same stream with checksum 00 -> both writes occur; then error=1, done=0, cpu_reset stays 1. A start pulse then reloads successfully.
- Header 00, and separately header 21h (33 > MEMORY_DEPTH) -> error=1 on the next edge, no mem_we, rx_ready=0.
- Valid stream with random 0–3 cycle gaps in rx_valid, plus a start pulse injected during DATA -> identical writes and result; the start is ignored.
- Reset asserted after 5 data bytes -> IDLE, no further mem_we. A fresh start plus the full stream -> byte_idx restarted, correct writes at 0x0 and 0x4, done=1.
